msg_store_forward: RTL

MSG_STORE_FORWARD -- requirements
Module: msg_store_forward

---
 rtl/msg_store_forward_pkg.sv | 24 ++
 rtl/msg_store_forward_beat_ram.sv | 46 ++++
 rtl/msg_store_forward.sv | 138 +++++++++++++
 3 files changed

// File: rtl/msg_store_forward_pkg.sv
// Shared types and constants for the message store-and-forward buffer.
package msg_store_forward_pkg;

  localparam int DATA_WIDTH_DEFAULT = 64;
  localparam int MOD_W              = 4;
  localparam int CNT_W              = 16;

  localparam logic [MOD_W-1:0] MOD_FULL = MOD_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } in_state_e;

  // Saturating counter add; inc is at most 2 (abandon plus overflow/bad-mod in one beat).
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/msg_store_forward_beat_ram.sv
// Beat storage: DEPTH entries of {data, end, mod}, one write port, one combinational read port.
module msg_beat_ram
  import msg_store_forward_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_end,
  input  logic [MOD_W-1:0]      i_wr_mod,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_end,
  output logic [MOD_W-1:0]      o_rd_mod
);

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic                  r_end  [DEPTH];
  logic [MOD_W-1:0]      r_mod  [DEPTH];

  // NOTE: the array is deliberately reset so the idle output bus reads all-zero;
  // this forces flops rather than RAM macros, which is acceptable at this depth.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_end[i]  <= 1'b0;
        r_mod[i]  <= '0;
      end
    end else if (i_wr_en) begin
      r_data[i_wr_addr] <= i_wr_data;
      r_end[i_wr_addr]  <= i_wr_end;
      r_mod[i_wr_addr]  <= i_wr_mod;
    end
  end

  assign o_rd_data = r_data[i_rd_addr];
  assign o_rd_end  = r_end[i_rd_addr];
  assign o_rd_mod  = r_mod[i_rd_addr];

endmodule

// File: rtl/msg_store_forward.sv
// Store-and-forward message buffer: only fully received, well-formed messages are forwarded.
module msg_store_forward
  import msg_store_forward_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  InBus_Valid,
  input  logic                  InBus_Start_Msg,
  input  logic                  InBus_End_Msg,
  input  logic [MOD_W-1:0]      InBus_Mod,
  input  logic [DATA_WIDTH-1:0] InBus_Data,
  output logic                  OutBus_Valid,
  input  logic                  OutBus_Ready,
  output logic                  OutBus_Start_Msg,
  output logic                  OutBus_End_Msg,
  output logic [MOD_W-1:0]      OutBus_Mod,
  output logic [DATA_WIDTH-1:0] OutBus_Data,
  output logic [CNT_W-1:0]      Msg_Count,
  output logic [CNT_W-1:0]      Drop_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  in_state_e        r_state;
  logic [PW-1:0]    r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic             r_start_flag;
  logic [CNT_W-1:0] r_msg_cnt, r_drop_cnt;

  logic             w_rd_fire, w_rd_end;
  logic [PW-1:0]    w_base, w_used;
  logic             w_full, w_mod_bad;
  logic             w_take, w_wr_en, w_commit;
  logic [1:0]       w_drop_inc;
  logic [PW-1:0]    w_next_wr;
  in_state_e        w_next_state;

  assign OutBus_Valid = (r_rd_ptr != r_commit_ptr);
  assign w_rd_fire    = OutBus_Valid & OutBus_Ready;

  // A Start beat in RECV restarts at the commit point, so fullness is judged from there.
  assign w_base    = (r_state == ST_RECV && InBus_Start_Msg) ? r_commit_ptr : r_wr_ptr;
  assign w_used    = w_base - r_rd_ptr;
  assign w_full    = (w_used == PW'(DEPTH)) && !w_rd_fire;
  assign w_mod_bad = InBus_End_Msg && (InBus_Mod == '0 || InBus_Mod > MOD_FULL);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_take       = 1'b0;
    w_wr_en      = 1'b0;
    w_commit     = 1'b0;
    w_drop_inc   = 2'd0;
    w_next_wr    = r_wr_ptr;
    w_next_state = r_state;
    if (InBus_Valid) begin
      if (r_state == ST_RECV) begin
        w_take = 1'b1;
        if (InBus_Start_Msg) begin
          w_drop_inc = 2'd1;
          w_next_wr  = r_commit_ptr;
        end
      end else if (InBus_Start_Msg) begin
        w_take = 1'b1;
      end else begin
        if (r_state == ST_IDLE) w_drop_inc = 2'd1;
        w_next_state = InBus_End_Msg ? ST_IDLE : ST_DISCARD;
      end

      if (w_take) begin
        if (w_full) begin
          w_drop_inc   = w_drop_inc + 2'd1;
          w_next_wr    = r_commit_ptr;
          w_next_state = InBus_End_Msg ? ST_IDLE : ST_DISCARD;
        end else if (w_mod_bad) begin
          w_drop_inc   = w_drop_inc + 2'd1;
          w_next_wr    = r_commit_ptr;
          w_next_state = ST_IDLE;
        end else begin
          w_wr_en      = 1'b1;
          w_next_wr    = w_base + PW'(1);
          w_commit     = InBus_End_Msg;
          w_next_state = InBus_End_Msg ? ST_IDLE : ST_RECV;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_start_flag <= 1'b1;
      r_msg_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wr_ptr   <= w_next_wr;
      r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
      if (w_commit) begin
        r_commit_ptr <= w_next_wr;
        r_msg_cnt    <= sat_add(r_msg_cnt, 2'd1);
      end
      if (w_rd_fire) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_start_flag <= w_rd_end;
      end
    end
  end

  msg_beat_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_base[AW-1:0]),
    .i_wr_data (InBus_Data),
    .i_wr_end  (InBus_End_Msg),
    .i_wr_mod  (InBus_End_Msg ? InBus_Mod : MOD_FULL),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (OutBus_Data),
    .o_rd_end  (w_rd_end),
    .o_rd_mod  (OutBus_Mod)
  );

  assign OutBus_End_Msg   = w_rd_end;
  assign OutBus_Start_Msg = r_start_flag & OutBus_Valid;
  assign Msg_Count        = r_msg_cnt;
  assign Drop_Count       = r_drop_cnt;

endmodule
